// File: rtl/downcount_ctrl.sv
// downcount_ctrl
//   Sequencing controller for a loadable down-counter (downcount: R, Resetn,
//   Clock, E, L, Q). A one-cycle Start request becomes a load / count /
//   terminal-detect / done sequence. The controller runs either one-shot or
//   with periodic auto-reload, supports Pause and Abort, and keeps a
//   saturating count of completed periods.
//
// Ports
//   Clock    in   system clock, rising edge
//   Resetn   in   asynchronous active-low reset
//   Start    in   single-cycle start request (ignored while busy)
//   Abort    in   return to IDLE from any active state
//   Pause    in   level; holds counting while in RUN
//   Mode     in   0 = one-shot, 1 = periodic; sampled at Start
//   Period   in   [n]  value to load; sampled at Start, 0 is rejected
//   Q        in   [n]  current value of the down-counter
//   L        out  load strobe to the counter
//   E        out  count enable to the counter
//   R        out  [n]  load value to the counter
//   Busy     out  high in every state except IDLE
//   Done     out  one-cycle pulse per completed period
//   Periods  out  [CW] completed periods since the last Start, saturating
//
// States
//   state | meaning
//   IDLE  | waiting for Start, counter untouched
//   LOAD  | L asserted for one cycle, counter takes R
//   RUN   | E asserted while Q != 0 and Pause is low
//   PAUSE | counting held until Pause drops
//   DONE  | Done pulse; reload (periodic) or return to IDLE (one-shot)
//
// Busy, Done, R and Periods come straight from flops (the state register
// is one-hot, so Busy and Done are single-bit decodes). E, and L while
// Abort is high, are gated combinationally so the counter stops on the
// same cycle Abort is raised.

module downcount_ctrl #(
    parameter int n  = 8,
    parameter int CW = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          Abort,
    input  logic          Pause,
    input  logic          Mode,
    input  logic [n-1:0]  Period,
    input  logic [n-1:0]  Q,
    output logic          L,
    output logic          E,
    output logic [n-1:0]  R,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Periods
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        LOAD  = 5'b00010,
        RUN   = 5'b00100,
        PAUSE = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    state_t          state_q, state_d;
    logic [n-1:0]    r_q, r_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   periods_q, periods_d;
    logic            q_zero;

    assign q_zero = (Q == '0);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            r_q       <= '0;
            mode_q    <= 1'b0;
            periods_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            mode_q    <= mode_d;
            periods_q <= periods_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        mode_d    = mode_q;
        periods_d = periods_q;
        L         = 1'b0;
        E         = 1'b0;

        case (state_q)
            IDLE: begin
                // Abort in the same cycle as Start wins; a zero period
                // would finish without ever counting, so it is refused.
                if (Start && !Abort && (Period != '0)) begin
                    r_d       = Period;
                    mode_d    = Mode;
                    periods_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                L       = !Abort;
                state_d = RUN;
            end
            RUN: begin
                E = !q_zero && !Pause && !Abort;
                // Terminal count takes priority over Pause.
                if (q_zero) begin
                    state_d = DONE;
                    if (periods_q != {CW{1'b1}}) begin
                        periods_d = periods_q + CW'(1);
                    end
                end else if (Pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (!Pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = mode_q ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps the period count: the increment taken on entry to
        // DONE is dropped so an aborted period is never counted.
        if (Abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            periods_d = periods_q;
        end
    end

    assign R       = r_q;
    assign Periods = periods_q;
    assign Busy    = (state_q != IDLE);
    assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_downcount_ctrl.sv
module tb_downcount_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Start, Abort, Pause, Mode;
    logic [7:0] Period;
    logic [7:0] Q;
    logic       L, E, Busy, Done;
    logic [7:0] R;
    logic [7:0] Periods;

    // second instance with a 2-bit period counter for saturation
    logic       Start2;
    logic [7:0] Q2;
    logic       L2, E2, Busy2, Done2;
    logic [7:0] R2;
    logic [1:0] Periods2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -1;
    int e_cnt = 0;

    always #5 Clock = ~Clock;

    downcount_ctrl #(.n(8), .CW(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
        .Pause(Pause), .Mode(Mode), .Period(Period), .Q(Q),
        .L(L), .E(E), .R(R), .Busy(Busy), .Done(Done), .Periods(Periods)
    );

    downcount_ctrl #(.n(8), .CW(2)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start2), .Abort(1'b0),
        .Pause(1'b0), .Mode(1'b1), .Period(8'd1), .Q(Q2),
        .L(L2), .E(E2), .R(R2), .Busy(Busy2), .Done(Done2), .Periods(Periods2)
    );

    // Behavioural down-counters sitting beside each controller.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn)  Q <= 8'd0;
        else if (L)   Q <= R;
        else if (E)   Q <= Q - 8'd1;
    end

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn)  Q2 <= 8'd0;
        else if (L2)  Q2 <= R2;
        else if (E2)  Q2 <= Q2 - 8'd1;
    end

    // Reference model: sequence flags plus the predicted counter value.
    bit         m_idle, m_load, m_hold, m_fin, m_mode;
    logic [7:0] m_r, m_q, m_per;

    task automatic model_reset();
        m_idle = 1'b1; m_load = 1'b0; m_hold = 1'b0; m_fin = 1'b0;
        m_mode = 1'b0; m_r = 8'd0; m_q = 8'd0; m_per = 8'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs,
    // then advance the model across the rising edge.
    task automatic step(input logic st, input logic ab, input logic pa,
                        input logic md, input logic [7:0] pd);
        logic       xl, xe, running;
        logic [7:0] q_pre;
        Start = st; Abort = ab; Pause = pa; Mode = md; Period = pd;
        #1;
        running = !m_idle && !m_load && !m_hold && !m_fin;
        xl = m_load && !ab;
        xe = running && (m_q != 8'd0) && !pa && !ab;
        chk("L", L, xl);
        chk("E", E, xe);
        chk("Busy", Busy, !m_idle);
        chk("Done", Done, m_fin);
        chk("R", R, m_r);
        chk("Periods", Periods, m_per);
        chk("Q", Q, m_q);
        chk("L_and_E", L & E, 1'b0);
        if (Done === 1'b1) last_done = cyc;
        if (E === 1'b1) e_cnt++;
        @(posedge Clock);
        q_pre = m_q;
        if (xl)      m_q = m_r;
        else if (xe) m_q = m_q - 8'd1;
        if (ab) begin
            if (!m_idle) begin
                m_idle = 1'b1; m_load = 1'b0; m_hold = 1'b0; m_fin = 1'b0;
            end
        end else if (m_idle) begin
            if (st && pd != 8'd0) begin
                m_idle = 1'b0; m_load = 1'b1; m_r = pd; m_mode = md; m_per = 8'd0;
            end
        end else if (m_load) begin
            m_load = 1'b0;
        end else if (m_fin) begin
            m_fin = 1'b0;
            if (m_mode) m_load = 1'b1;
            else        m_idle = 1'b1;
        end else if (m_hold) begin
            if (!pa) m_hold = 1'b0;
        end else begin
            if (q_pre == 8'd0) begin
                m_fin = 1'b1;
                if (m_per != 8'hFF) m_per = m_per + 8'd1;
            end else if (pa) begin
                m_hold = 1'b1;
            end
        end
        cyc++;
        @(negedge Clock);
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        int s;
        int dn;
        int guard;
        Resetn = 1'b0; Start = 1'b0; Abort = 1'b0; Pause = 1'b0;
        Mode = 1'b0; Period = 8'd0; Start2 = 1'b0;
        model_reset();
        @(negedge Clock);
        #1;
        chk("rst_L", L, 1'b0);
        chk("rst_E", E, 1'b0);
        chk("rst_R", R, 8'd0);
        chk("rst_Busy", Busy, 1'b0);
        chk("rst_Done", Done, 1'b0);
        chk("rst_Periods", Periods, 8'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        idle_steps(2);

        // One-shot, period 5
        e_cnt = 0; last_done = -1;
        s = cyc;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        idle_steps(10);
        chk("oneshot_done_lat", last_done - s, 8);
        chk("oneshot_e_cycles", e_cnt, 5);
        chk("oneshot_periods", Periods, 8'd1);
        chk("oneshot_busy", Busy, 1'b0);

        // Periodic, period 3, then Abort
        s = cyc; dn = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            if (last_done == cyc - 1) dn++;
        end
        chk("periodic_done_count", dn, 3);
        chk("periodic_last_done", last_done - s, 18);
        chk("periodic_periods", Periods, 8'd3);
        last_done = -1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        idle_steps(8);
        chk("abort_no_done", last_done, -1);
        chk("abort_periods", Periods, 8'd3);

        // Pause for three cycles once Q reaches 4
        s = cyc; last_done = -1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
        idle_steps(3);
        for (int i = 0; i < 3; i++) begin
            chk("pause_q_frozen", Q, 8'd4);
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        chk("pause_q_resume", Q, 8'd4);
        idle_steps(10);
        chk("pause_done_lat", last_done - s, 13);

        // Edge cases
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("zero_period_idle", Busy, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        idle_steps(2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd9);
        chk("busy_start_R", R, 8'd5);
        idle_steps(8);
        chk("busy_start_mode", Busy, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        chk("abort_start_idle", Busy, 1'b0);
        idle_steps(2);

        // Reset asserted mid-RUN with Q=3
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
        guard = 0;
        while (m_q != 8'd3 && guard < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            guard++;
        end
        chk("rst_mid_q", Q, 8'd3);
        #2 Resetn = 1'b0;
        #1;
        chk("rstmid_L", L, 1'b0);
        chk("rstmid_E", E, 1'b0);
        chk("rstmid_R", R, 8'd0);
        chk("rstmid_Busy", Busy, 1'b0);
        chk("rstmid_Done", Done, 1'b0);
        chk("rstmid_Periods", Periods, 8'd0);
        chk("rstmid_Q", Q, 8'd0);
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        idle_steps(4);

        // Saturation on the 2-bit period counter, periodic period 1
        Start2 = 1'b1;
        for (int j = 0; j < 24; j++) begin
            #1;
            chk("sat_done", Done2, (j >= 4) && (j % 4 == 0));
            chk("sat_periods", Periods2, (j / 4 > 3) ? 3 : j / 4);
            @(posedge Clock);
            @(negedge Clock);
            Start2 = 1'b0;
        end

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
